// File: rtl/commit_cfi_monitor.sv
// ----------------------------------------------------------------------------
// commit_cfi_monitor
//
// Shadow-stack control-flow integrity monitor placed directly behind the
// commit stage. Calls push their return address, returns pop the top entry
// and compare it with the resolved jump target. Any mismatch, overflow or
// underflow sets a sticky violation that stays until clear or reset.
//
// Ports:
//   clk_i                      clock
//   rst_i                      synchronous active-high reset
//   en_i                       monitor enable; when low, commits are ignored
//   clear_i                    empty the stack and drop the violation
//   commit_ack_i[p]            commit port p retired an instruction
//   commit_pc_i[p]             pc of that instruction
//   commit_is_compressed_i[p]  16-bit encoding (return address = pc + 2)
//   commit_is_call_i[p]        call (JAL/JALR writing x1/x5)
//   commit_is_ret_i[p]         return (JALR reading x1/x5)
//   commit_target_i[p]         resolved jump target
//   flow_integrity_violated_o  sticky violation flag
//   violation_cause_o          00 none, 01 mismatch, 10 overflow, 11 underflow
//   violation_pc_o             pc of the first offending instruction
//   depth_o                    current stack occupancy
// ----------------------------------------------------------------------------
module commit_cfi_monitor #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned VLEN            = 64,
    localparam int unsigned DW             = $clog2(DEPTH + 1),
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       en_i,
    input  logic                                       clear_i,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]       commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_is_compressed_i,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_is_call_i,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_is_ret_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]       commit_target_i,
    output logic                                       flow_integrity_violated_o,
    output logic [1:0]                                 violation_cause_o,
    output logic [VLEN-1:0]                            violation_pc_o,
    output logic [DW-1:0]                              depth_o
);

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_MISMATCH  = 2'b01,
        CAUSE_OVERFLOW  = 2'b10,
        CAUSE_UNDERFLOW = 2'b11
    } cause_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [VLEN-1:0] r_stack [DEPTH];
    logic [DW-1:0]   r_depth;
    logic            r_violated;
    cause_e          r_cause;
    logic [VLEN-1:0] r_vpc;

    // ------------------------------------------------------------------
    // Combinational view of the stack, walked port 0 then port 1
    // ------------------------------------------------------------------
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] w_ra;
    logic [NR_COMMIT_PORTS-1:0]           w_we;
    logic [NR_COMMIT_PORTS-1:0][AW-1:0]   w_waddr;
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] w_wdata;

    logic [DW-1:0]   w_cur;
    logic [DW-1:0]   w_idx;
    logic            w_fwd_valid;
    logic [VLEN-1:0] w_fwd_data;
    logic [VLEN-1:0] w_top;
    logic            w_stop;
    logic            w_viol;
    cause_e          w_cause;
    logic [VLEN-1:0] w_vpc;
    logic            w_accept;

    // Return address wraps modulo 2^VLEN; the carry out is dropped.
    always_comb begin
        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            w_ra[p] = commit_pc_i[p] +
                      (commit_is_compressed_i[p] ? VLEN'(2) : VLEN'(4));
        end
    end

    // Nothing is processed while reset, clear, disabled or already violated.
    assign w_accept = en_i & ~r_violated & ~clear_i & ~rst_i;

    always_comb begin
        w_cur       = r_depth;
        w_idx       = '0;
        w_fwd_valid = 1'b0;
        w_fwd_data  = '0;
        w_top       = '0;
        w_stop      = 1'b0;
        w_viol      = 1'b0;
        w_cause     = CAUSE_NONE;
        w_vpc       = '0;
        w_we        = '0;
        w_waddr     = '0;
        w_wdata     = '0;

        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (w_accept && !w_stop && commit_ack_i[p]) begin
                // Pop-and-check. The top entry may be one an older port
                // pushed this very cycle and is not yet in the RAM, so it is
                // taken from the forwarding register instead.
                if (commit_is_ret_i[p]) begin
                    if (w_cur == '0) begin
                        w_stop  = 1'b1;
                        w_viol  = 1'b1;
                        w_cause = CAUSE_UNDERFLOW;
                        w_vpc   = commit_pc_i[p];
                    end else begin
                        w_idx       = w_cur - DW'(1);
                        w_top       = w_fwd_valid ? w_fwd_data : r_stack[w_idx[AW-1:0]];
                        w_cur       = w_idx;
                        w_fwd_valid = 1'b0;
                        if (w_top != commit_target_i[p]) begin
                            w_stop  = 1'b1;
                            w_viol  = 1'b1;
                            w_cause = CAUSE_MISMATCH;
                            w_vpc   = commit_pc_i[p];
                        end
                    end
                end

                // Push. For a call+ret swap the pop above freed a slot, so
                // the full check can never fire on that path.
                if (commit_is_call_i[p] && !w_stop) begin
                    if (w_cur == DW'(DEPTH)) begin
                        w_stop  = 1'b1;
                        w_viol  = 1'b1;
                        w_cause = CAUSE_OVERFLOW;
                        w_vpc   = commit_pc_i[p];
                    end else begin
                        w_we[p]     = 1'b1;
                        w_waddr[p]  = w_cur[AW-1:0];
                        w_wdata[p]  = w_ra[p];
                        w_cur       = w_cur + DW'(1);
                        w_fwd_valid = 1'b1;
                        w_fwd_data  = w_ra[p];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_depth    <= '0;
            r_violated <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_vpc      <= '0;
        end else begin
            r_depth <= w_cur;
            if (w_viol) begin
                r_violated <= 1'b1;
                r_cause    <= w_cause;
                r_vpc      <= w_vpc;
            end
        end
    end

    // Later ports win when two pushes hit the same slot (ret+call forwarding).
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (w_we[p]) begin
                r_stack[w_waddr[p]] <= w_wdata[p];
            end
        end
    end

    assign flow_integrity_violated_o = r_violated;
    assign violation_cause_o         = r_cause;
    assign violation_pc_o            = r_vpc;
    assign depth_o                   = r_depth;

endmodule

// File: tb/tb_commit_cfi_monitor.sv
module tb_commit_cfi_monitor;

    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned VLEN  = 32;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst, en, clr;
    logic [NP-1:0]            ack, cmp, call, ret;
    logic [NP-1:0][VLEN-1:0]  pc, tgt;
    logic                     viol;
    logic [1:0]               cause;
    logic [VLEN-1:0]          vpc;
    logic [DW-1:0]            depth;

    always #5 clk = ~clk;

    commit_cfi_monitor #(
        .NR_COMMIT_PORTS (NP),
        .DEPTH           (DEPTH),
        .VLEN            (VLEN)
    ) dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .en_i                      (en),
        .clear_i                   (clr),
        .commit_ack_i              (ack),
        .commit_pc_i               (pc),
        .commit_is_compressed_i    (cmp),
        .commit_is_call_i          (call),
        .commit_is_ret_i           (ret),
        .commit_target_i           (tgt),
        .flow_integrity_violated_o (viol),
        .violation_cause_o         (cause),
        .violation_pc_o            (vpc),
        .depth_o                   (depth)
    );

    typedef struct {
        string       name;
        logic        rst, en, clr;
        logic [1:0]  ack, call, ret, cmp;
        logic [31:0] pc0, t0, pc1, t1;
        logic        ev;
        logic [1:0]  ec;
        logic [31:0] epc;
        logic [3:0]  ed;
    } vec_t;

    vec_t        vq[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic add(input string nm, input logic r, input logic e, input logic c,
                       input logic [1:0] a, input logic [1:0] cl, input logic [1:0] rt,
                       input logic [1:0] cp, input logic [31:0] p0, input logic [31:0] t0,
                       input logic [31:0] p1, input logic [31:0] t1, input logic ev,
                       input logic [1:0] ec, input logic [31:0] epc, input logic [3:0] ed);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.clr = c;
        v.ack = a; v.call = cl; v.ret = rt; v.cmp = cp;
        v.pc0 = p0; v.t0 = t0; v.pc1 = p1; v.t1 = t1;
        v.ev = ev; v.ec = ec; v.epc = epc; v.ed = ed;
        vq.push_back(v);
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic apply(input logic r, input logic e, input logic c,
                         input logic [1:0] a, input logic [1:0] cl, input logic [1:0] rt,
                         input logic [1:0] cp, input logic [31:0] p0, input logic [31:0] t0,
                         input logic [31:0] p1, input logic [31:0] t1);
        rst = r; en = e; clr = c; ack = a; call = cl; ret = rt; cmp = cp;
        pc[0] = p0; tgt[0] = t0; pc[1] = p1; tgt[1] = t1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check(input string nm, input logic ev, input logic [1:0] ec,
                         input logic [31:0] epc, input logic [3:0] ed);
        chk1({nm, ".violated"}, 32'(viol), 32'(ev));
        chk1({nm, ".cause"},    32'(cause), 32'(ec));
        chk1({nm, ".vpc"},      vpc, epc);
        chk1({nm, ".depth"},    32'(depth), 32'(ed));
    endtask

    task automatic call0(input logic [31:0] p);
        apply(0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, p, 0, 0, 0);
    endtask

    task automatic idle(input logic e, input logic c, input logic r);
        apply(r, e, c, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; ack = '0; call = '0; ret = '0; cmp = '0;
        pc = '0; tgt = '0;
        @(negedge clk);

        //   name        rst en clr ack   call  ret   cmp   pc0           t0            pc1      t1       ev ec    epc      ed
        add("reset",      1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0,           0,            0,       0,       0, 2'd0, 0,       0);
        add("nest_c1",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h80000000, 0,           0,       0,       0, 2'd0, 0,       1);
        add("nest_c2",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b01, 32'h80000100, 0,           0,       0,       0, 2'd0, 0,       2);
        add("nest_r1",    0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h80000200, 32'h80000102, 0,      0,       0, 2'd0, 0,       1);
        add("nest_r2",    0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h80000300, 32'h80000004, 0,      0,       0, 2'd0, 0,       0);
        add("mm_call",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h1000,    0,            0,       0,       0, 2'd0, 0,       1);
        add("mm_ret",     0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h1100,    32'h2000,     0,       0,       1, 2'd1, 32'h1100, 0);
        add("mm_frozen",  0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h1200,    0,            0,       0,       1, 2'd1, 32'h1100, 0);
        add("clear1",     0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,           0,            0,       0,       0, 2'd0, 0,       0);
        add("dual_ok",    0, 1, 0, 2'b11, 2'b01, 2'b10, 2'b00, 32'h3000,    0,            32'h3010, 32'h3004, 0, 2'd0, 0,     0);
        add("dual_mm",    0, 1, 0, 2'b11, 2'b01, 2'b10, 2'b00, 32'h3000,    0,            32'h3010, 32'h3008, 1, 2'd1, 32'h3010, 0);
        add("clear2",     0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,           0,            0,       0,       0, 2'd0, 0,       0);
        add("p0_uf_p1c",  0, 1, 0, 2'b11, 2'b10, 2'b01, 2'b00, 32'h4000,    0,            32'h4010, 0,      1, 2'd3, 32'h4000, 0);
        add("clear3",     0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,           0,            0,       0,       0, 2'd0, 0,       0);
        add("rc_call",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h5000,    0,            0,       0,       0, 2'd0, 0,       1);
        add("rc_swap",    0, 1, 0, 2'b11, 2'b10, 2'b01, 2'b10, 32'h5100,    32'h5004,     32'h5200, 0,      0, 2'd0, 0,       1);
        add("rc_ret",     0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h5300,    32'h5202,     0,       0,       0, 2'd0, 0,       0);
        add("rr_call",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h6000,    0,            0,       0,       0, 2'd0, 0,       1);
        add("rr_uf",      0, 1, 0, 2'b11, 2'b00, 2'b11, 2'b00, 32'h6100,    32'h6004,     32'h6104, 32'h0,  1, 2'd3, 32'h6104, 0);
        add("clear4",     0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0,           0,            0,       0,       0, 2'd0, 0,       0);
        add("co_call",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h7000,    0,            0,       0,       0, 2'd0, 0,       1);
        add("co_swap",    0, 1, 0, 2'b01, 2'b01, 2'b01, 2'b00, 32'h7100,    32'h7004,     0,       0,       0, 2'd0, 0,       1);
        add("co_ret",     0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h7200,    32'h7104,     0,       0,       0, 2'd0, 0,       0);
        add("en_call",    0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h9000,    0,            0,       0,       0, 2'd0, 0,       1);
        add("en_off_mm",  0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h9100,    32'hDEAD,     0,       0,       0, 2'd0, 0,       1);
        add("noack_mm",   0, 1, 0, 2'b00, 2'b00, 2'b11, 2'b00, 32'h9200,    32'hDEAD,     0,       32'hBEEF, 0, 2'd0, 0,      1);
        add("en_ret",     0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h9300,    32'h9004,     0,       0,       0, 2'd0, 0,       0);
        add("wrap_call",  0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b01, 32'hFFFFFFFE, 0,           0,       0,       0, 2'd0, 0,       1);
        add("wrap_ret",   0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'h10,      32'h0,        0,       0,       0, 2'd0, 0,       0);
        add("clr_call0",  0, 1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 32'h100,     0,            0,       0,       0, 2'd0, 0,       1);
        add("clr_w_call", 0, 1, 1, 2'b01, 2'b01, 2'b00, 2'b00, 32'h200,     0,            0,       0,       0, 2'd0, 0,       0);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].en, vq[i].clr, vq[i].ack, vq[i].call, vq[i].ret, vq[i].cmp,
                  vq[i].pc0, vq[i].t0, vq[i].pc1, vq[i].t1);
            check(vq[i].name, vq[i].ev, vq[i].ec, vq[i].epc, vq[i].ed);
        end

        // Fill to DEPTH, then one more call overflows.
        for (int i = 0; i < int'(DEPTH); i++) begin
            call0(32'hA000_0000 + 32'(i * 'h100));
            check($sformatf("fill%0d", i), 0, 2'd0, 0, 4'(i + 1));
        end
        call0(32'hA000);
        check("overflow", 1, 2'd2, 32'hA000, 4'(DEPTH));
        // First violation wins: a later mismatch leaves everything frozen.
        apply(0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'hB000, 32'h0, 0, 0);
        check("first_wins", 1, 2'd2, 32'hA000, 4'(DEPTH));
        idle(0, 0, 0);
        check("sticky_en0", 1, 2'd2, 32'hA000, 4'(DEPTH));
        idle(1, 1, 0);
        check("clear_ovf", 0, 2'd0, 0, 0);
        apply(0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'hC000, 32'h0, 0, 0);
        check("underflow", 1, 2'd3, 32'hC000, 0);
        idle(1, 1, 0);

        // Two calls with one free slot: port 0 pushes, port 1 overflows.
        for (int i = 0; i < int'(DEPTH) - 1; i++) call0(32'hD000_0000 + 32'(i * 4));
        check("fill_m1", 0, 2'd0, 0, 4'(DEPTH - 1));
        apply(0, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 32'hD000, 0, 32'hD100, 0);
        check("dual_ovf", 1, 2'd2, 32'hD100, 4'(DEPTH));
        idle(1, 1, 0);

        // Reset mid-stream with five entries.
        for (int i = 0; i < 5; i++) call0(32'hE000_0000 + 32'(i * 4));
        check("depth5", 0, 2'd0, 0, 5);
        idle(1, 0, 1);
        check("rst_mid", 0, 2'd0, 0, 0);
        call0(32'hE000);
        apply(0, 1, 0, 2'b01, 2'b00, 2'b01, 2'b00, 32'hE100, 32'hE004, 0, 0);
        check("post_rst", 0, 2'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
